router_rd_ctrl: RTL and testbench

ROUTER_RD_CTRL -- requirements
Module: router_rd_ctrl

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_rr_arb.sv | 37 +++
 rtl/router_rd_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_router_rd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router read path.
// Header byte: [7:2] payload length, [1:0] destination address.
package router_pkg;

  localparam int NUM_PORTS    = 3;
  localparam int LEN_W        = 6;
  localparam int CNT_W        = LEN_W + 1;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HWAIT,
    BODY,
    TAIL
  } rd_state_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(NUM_PORTS - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/router_rr_arb.sv
// Round-robin grant over the FIFO ports; grant is combinational, pointer moves on upd.
// The search starts at the port after the last one recorded by upd.
module router_rr_arb
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 upd,
  output logic                 gnt_vld,
  output logic [1:0]           gnt_idx
);

  logic [1:0] last_q, last_d;
  logic [1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = rr_next(last_q);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = rr_next(cand);
    end
    last_d = (upd && gnt_vld) ? gnt_idx : last_q;
  end

  // Reset to the highest port so the first search begins at port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 2'(NUM_PORTS - 1);
    else      last_q <= last_d;
  end

endmodule

// File: rtl/router_rd_ctrl.sv
// Router read controller: drains one locked FIFO port per packet into the sink.
// Byte appears one cycle after its read strobe; reads stall while vld_out or sink_rdy is low.
module router_rd_ctrl
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       sink_rdy,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_first,
  output logic       pkt_last,
  output logic [1:0] pkt_port,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_abort
);

  rd_state_e        state_q, state_d;
  logic [1:0]       port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic             addr_bad_q, addr_bad_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;
  logic             aerr_q, aerr_d;
  logic             abort_q, abort_d;

  logic [NUM_PORTS-1:0] vld_v, srst_v;
  logic [7:0]           rd_byte, acc_nxt;
  logic [CNT_W-1:0]     hdr_len;
  logic                 vld_sel, srst_sel, can_rd, rd_en;
  logic                 gnt_vld, arb_upd;
  logic [1:0]           gnt_idx;

  assign vld_v  = {vld_out_2, vld_out_1, vld_out_0};
  assign srst_v = {soft_rst_2, soft_rst_1, soft_rst_0};

  always_comb begin
    unique case (port_q)
      2'd1:    rd_byte = data_out_1;
      2'd2:    rd_byte = data_out_2;
      default: rd_byte = data_out_0;
    endcase
  end

  assign vld_sel  = vld_v[port_q];
  assign srst_sel = srst_v[port_q];
  assign can_rd   = vld_sel && sink_rdy;
  assign acc_nxt  = acc_q ^ (valid_q ? rd_byte : 8'h00);
  // Remaining strobes after the header: payload plus the parity byte.
  assign hdr_len  = CNT_W'(rd_byte[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);

  router_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (vld_v),
    .upd     (arb_upd),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    addr_bad_d = addr_bad_q;
    rd_en      = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    perr_d     = 1'b0;
    aerr_d     = 1'b0;
    abort_d    = 1'b0;
    arb_upd    = 1'b0;

    if (state_q != IDLE && srst_sel) begin
      state_d    = IDLE;
      abort_d    = 1'b1;
      acc_d      = 8'h00;
      cnt_d      = '0;
      addr_bad_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_d      = 8'h00;
          cnt_d      = '0;
          addr_bad_d = 1'b0;
          if (gnt_vld) begin
            port_d  = gnt_idx;
            arb_upd = 1'b1;
            state_d = HDR;
          end
        end
        HDR: begin
          if (can_rd) begin
            rd_en   = 1'b1;
            first_d = 1'b1;
            state_d = HWAIT;
          end
        end
        HWAIT: begin
          acc_d      = acc_nxt;
          addr_bad_d = (rd_byte[HDR_ADDR_MSB:HDR_ADDR_LSB] != port_q);
          // Parity byte always follows, so reading here never over-runs the packet.
          if (can_rd) begin
            rd_en = 1'b1;
            cnt_d = hdr_len - CNT_W'(1);
            if (hdr_len == CNT_W'(1)) begin
              last_d  = 1'b1;
              state_d = TAIL;
            end else begin
              state_d = BODY;
            end
          end else begin
            cnt_d   = hdr_len;
            state_d = BODY;
          end
        end
        BODY: begin
          acc_d = acc_nxt;
          if (cnt_q != '0 && can_rd) begin
            rd_en = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              last_d  = 1'b1;
              state_d = TAIL;
            end
          end
        end
        TAIL: begin
          acc_d   = acc_nxt;
          done_d  = 1'b1;
          perr_d  = (acc_nxt != 8'h00);
          aerr_d  = addr_bad_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      port_q     <= 2'd0;
      cnt_q      <= '0;
      acc_q      <= 8'h00;
      addr_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      aerr_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      addr_bad_q <= addr_bad_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      aerr_q     <= aerr_d;
      abort_q    <= abort_d;
    end
  end

  assign read_enb_0 = rd_en && (port_q == 2'd0);
  assign read_enb_1 = rd_en && (port_q == 2'd1);
  assign read_enb_2 = rd_en && (port_q == 2'd2);
  assign pkt_data   = valid_q ? rd_byte : 8'h00;
  assign pkt_valid  = valid_q;
  assign pkt_first  = first_q;
  assign pkt_last   = last_q;
  assign pkt_port   = port_q;
  assign pkt_done   = done_q;
  assign parity_err = perr_q;
  assign addr_err   = aerr_q;
  assign pkt_abort  = abort_q;

endmodule

// File: tb/tb_router_rd_ctrl.sv
// Bench for router_rd_ctrl: behavioural port FIFOs feed the DUT, a byte/packet scoreboard checks the sink side.
module tb_router_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       sink_rdy;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] pkt_data;
  logic       pkt_valid, pkt_first, pkt_last;
  logic [1:0] pkt_port;
  logic       pkt_done, parity_err, addr_err, pkt_abort;

  typedef struct packed {logic [7:0] d; logic f; logic l; logic [1:0] p;} byte_exp_t;
  typedef struct packed {logic perr; logic aerr; logic abort;} pkt_exp_t;

  byte_exp_t  exp_q[$];
  pkt_exp_t   pkt_q[$];
  logic [7:0] fq[3][$];
  int         rd_cnt[3];
  int         exp_rd[3];
  logic [2:0] re_lat = 3'b000;
  bit         stall_win = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  router_rd_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .soft_rst_0 (soft_rst_0),
    .soft_rst_1 (soft_rst_1),
    .soft_rst_2 (soft_rst_2),
    .sink_rdy   (sink_rdy),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_first  (pkt_first),
    .pkt_last   (pkt_last),
    .pkt_port   (pkt_port),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_abort  (pkt_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vld();
    vld_out_0 = (fq[0].size() != 0);
    vld_out_1 = (fq[1].size() != 0);
    vld_out_2 = (fq[2].size() != 0);
  endtask

  // Loads one packet into a port FIFO and the expected sink bytes into the scoreboard.
  task automatic push_pkt(input int p, input int len, input int addr, input logic [7:0] seed,
                          input bit bad_par, input int n_out, input bit abort);
    logic [7:0] b;
    logic [7:0] par;
    byte_exp_t  e;
    pkt_exp_t   pe;
    par = 8'h00;
    for (int i = 0; i < len + 2; i++) begin
      if (i == 0)        b = {len[5:0], addr[1:0]};
      else if (i <= len) b = 8'(seed * i);
      else               b = bad_par ? 8'h00 : par;
      if (i <= len) par = par ^ b;
      fq[p].push_back(b);
      if (i < n_out) begin
        e.d = b;
        e.f = (i == 0);
        e.l = (i == len + 1);
        e.p = p[1:0];
        exp_q.push_back(e);
      end
    end
    exp_rd[p] += n_out;
    pe.perr  = bad_par;
    pe.aerr  = (addr != p);
    pe.abort = abort;
    pkt_q.push_back(pe);
    set_vld();
  endtask

  task automatic wait_rd(input int p, input int target);
    for (int i = 0; i < 300 && rd_cnt[p] < target; i++) @(negedge clk);
    if (rd_cnt[p] < target) chk("rd_timeout", rd_cnt[p], target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && (exp_q.size() != 0 || pkt_q.size() != 0); i++) @(negedge clk);
    if (exp_q.size() != 0 || pkt_q.size() != 0) chk("idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  // FIFO model: a strobe seen in cycle N presents its byte just after the next rising edge.
  initial begin
    logic [7:0] d;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (re_lat[p] && fq[p].size() > 0) begin
          d = fq[p].pop_front();
          case (p)
            0:       data_out_0 = d;
            1:       data_out_1 = d;
            default: data_out_2 = d;
          endcase
        end
      end
      set_vld();
    end
  end

  // Sink-side monitor and scoreboard.
  initial begin
    logic [2:0] re;
    byte_exp_t  e;
    pkt_exp_t   pe;
    forever begin
      @(negedge clk);
      re = {read_enb_2, read_enb_1, read_enb_0};
      re_lat = re;
      if (rst) begin
        if (re != 3'b000) begin
          chk("read_onehot", 32'($onehot(re)), 1);
          for (int p = 0; p < 3; p++) if (re[p]) rd_cnt[p]++;
        end
        if (stall_win) chk("stall_re", re, 0);
        if (pkt_valid) begin
          if (exp_q.size() == 0) chk("extra_byte", pkt_data, 32'hFFFF);
          else begin
            e = exp_q.pop_front();
            chk("byte_data", pkt_data, e.d);
            chk("byte_first", pkt_first, e.f);
            chk("byte_last", pkt_last, e.l);
            chk("byte_port", pkt_port, e.p);
          end
        end
        if (pkt_done) begin
          if (pkt_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            pe = pkt_q.pop_front();
            chk("done_not_abort", 1'b0, pe.abort);
            chk("parity_err", parity_err, pe.perr);
            chk("addr_err", addr_err, pe.aerr);
          end
        end
        if (pkt_abort) begin
          if (pkt_q.size() == 0) chk("abort_unexpected", 1, 0);
          else begin
            pe = pkt_q.pop_front();
            chk("abort_expected", 1'b1, pe.abort);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    rst = 1'b0;
    {vld_out_0, vld_out_1, vld_out_2} = 3'b000;
    {data_out_0, data_out_1, data_out_2} = 24'h0;
    {soft_rst_0, soft_rst_1, soft_rst_2} = 3'b000;
    sink_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin rd_cnt[p] = 0; exp_rd[p] = 0; end

    repeat (2) @(negedge clk);
    chk("rst_read_enb", {read_enb_2, read_enb_1, read_enb_0}, 0);
    chk("rst_flags", {pkt_valid, pkt_first, pkt_last, pkt_done, parity_err, addr_err, pkt_abort}, 0);
    chk("rst_pkt_data", pkt_data, 0);
    chk("rst_pkt_port", pkt_port, 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk); #2;

    // Port 1, L=3, good parity; strobes must be back to back.
    push_pkt(1, 3, 1, 8'h11, 1'b0, 5, 1'b0);
    wait_rd(1, 1);
    cyc = 0;
    while (rd_cnt[1] < 5 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("t1_consecutive", cyc, 4);
    wait_idle();

    // Same packet with parity forced to 0; a soft reset on an unlocked port must be ignored.
    push_pkt(1, 3, 1, 8'h11, 1'b1, 5, 1'b0);
    repeat (2) @(posedge clk);
    #2 soft_rst_0 = 1'b1;
    @(posedge clk); #2 soft_rst_0 = 1'b0;
    wait_idle();

    // Address mismatch on port 0.
    push_pkt(0, 2, 2, 8'h40, 1'b0, 4, 1'b0);
    wait_idle();

    // After port 0, ports 2 and 0 both pending: 2 wins first.
    push_pkt(2, 1, 2, 8'h70, 1'b0, 3, 1'b0);
    push_pkt(0, 4, 0, 8'h21, 1'b0, 6, 1'b0);
    wait_idle();

    // Zero-length payload.
    push_pkt(2, 0, 2, 8'h00, 1'b0, 2, 1'b0);
    wait_idle();

    // Sink stall for 4 cycles mid-body.
    base = rd_cnt[1];
    push_pkt(1, 6, 1, 8'h13, 1'b0, 8, 1'b0);
    wait_rd(1, base + 3);
    @(posedge clk); #2 sink_rdy = 1'b0; stall_win = 1'b1;
    repeat (4) @(posedge clk);
    #2 sink_rdy = 1'b1; stall_win = 1'b0;
    wait_idle();

    // Soft reset of the locked port mid-body.
    base = rd_cnt[1];
    push_pkt(1, 5, 1, 8'h2B, 1'b0, 3, 1'b1);
    wait_rd(1, base + 3);
    @(posedge clk); #2 soft_rst_1 = 1'b1;
    fq[1].delete();
    set_vld();
    @(posedge clk); #2 soft_rst_1 = 1'b0;
    @(negedge clk);
    chk("abort_idle_re", {read_enb_2, read_enb_1, read_enb_0}, 0);
    chk("abort_no_done", pkt_done, 0);
    wait_idle();

    // Pointer moved past the aborted port 1: port 2 before port 1.
    push_pkt(2, 2, 2, 8'h66, 1'b0, 4, 1'b0);
    push_pkt(1, 2, 1, 8'h55, 1'b0, 4, 1'b0);
    wait_idle();

    // Hard reset mid-packet on port 2: silent drop.
    base = rd_cnt[2];
    push_pkt(2, 10, 2, 8'h05, 1'b0, 3, 1'b0);
    wait_rd(2, base + 3);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_read_enb", {read_enb_2, read_enb_1, read_enb_0}, 0);
    chk("mid_rst_flags", {pkt_valid, pkt_done, pkt_abort}, 0);
    chk("mid_rst_port", pkt_port, 0);
    fq[2].delete();
    exp_q.delete();
    pkt_q.delete();
    set_vld();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;

    for (int p = 0; p < 3; p++) chk($sformatf("reads_port%0d", p), rd_cnt[p], exp_rd[p]);
    chk("bytes_left", exp_q.size(), 0);
    chk("pkts_left", pkt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
